// File: rtl/wb_slot_scheduler_m1_pkg.sv
// Shared types for the writeback slot scheduler: source encoding and default table depth.
package m1_wb_pkg;

   typedef enum logic [1:0] {
      WB_ALU = 2'd0,
      WB_MUL = 2'd1,
      WB_DIV = 2'd2,
      WB_LSU = 2'd3
   } wb_src_e;

   localparam int WB_MAX_LAT    = 8;
   localparam int WB_STARVE_LIM = 4;

   function automatic logic is_fixed_src(wb_src_e s);
      return (s == WB_ALU) || (s == WB_MUL);
   endfunction

endpackage

// File: rtl/wb_slot_scheduler_m1_arb.sv
// Two-way round-robin arbiter: one-hot grant when enabled, pointer moves to the loser after a grant.
module wb_rr_arbiter_m1 (
   input  logic       clk,
   input  logic       srst_i,
   input  logic       en_i,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o
);

   logic ptr_q, ptr_d;

   always_comb begin
      gnt_o = 2'b00;
      if (en_i) begin
         if (!ptr_q) begin
            if (req_i[0])      gnt_o = 2'b01;
            else if (req_i[1]) gnt_o = 2'b10;
         end else begin
            if (req_i[1])      gnt_o = 2'b10;
            else if (req_i[0]) gnt_o = 2'b01;
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (gnt_o[0])      ptr_d = 1'b1;
      else if (gnt_o[1]) ptr_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (srst_i) ptr_q <= 1'b0;
      else        ptr_q <= ptr_d;
   end

endmodule

// File: rtl/wb_slot_scheduler_m1.sv
// Books the single writeback port ahead of time for fixed- and variable-latency units.
// Optional WB_SCHED_STATS_EN adds saturating hold/wait statistics counters.
module wb_slot_scheduler_m1
   import m1_wb_pkg::*;
#(
   parameter int  MAX_LAT    = WB_MAX_LAT,
   parameter int  STARVE_LIM = WB_STARVE_LIM,
   localparam int LW         = $clog2(MAX_LAT + 1),
   localparam int WW         = $clog2(STARVE_LIM + 1)
) (
   input  logic               clk,
   input  logic               sync_rst,
   input  logic               clk_en,
   input  logic               issue_req,
   input  wb_src_e            issue_src,
   input  logic [LW-1:0]      issue_lat,
   output logic               issue_grant,
   input  logic [1:0]         var_req,
   output logic [1:0]         var_grant,
   output logic               wb_valid,
   output wb_src_e            wb_src,
   output logic [MAX_LAT-1:0] busy_map
`ifdef WB_SCHED_STATS_EN
   ,
   output logic [15:0]        stat_issue_hold,
   output logic [15:0]        stat_var_wait
`endif
);

   logic [MAX_LAT:1] res_q, res_d;
   wb_src_e          own_q [MAX_LAT:1];
   wb_src_e          own_d [MAX_LAT:1];
   logic [WW-1:0]    wait_q [2];
   logic [WW-1:0]    wait_d [2];
   logic             wb_valid_q, wb_valid_d;
   wb_src_e          wb_src_q, wb_src_d;

   logic advance, starve, lat_ok, res_hit, issue_l1, slot_free;

   assign advance = clk_en & ~sync_rst;
   assign lat_ok  = (issue_lat >= LW'(1)) && (issue_lat <= LW'(MAX_LAT));

   always_comb begin
      res_hit = 1'b0;
      for (int k = 1; k <= MAX_LAT; k++) begin
         if (issue_lat == LW'(k)) res_hit = res_q[k];
      end
   end

   always_comb begin
      starve = 1'b0;
      for (int i = 0; i < 2; i++) begin
         if (wait_q[i] >= WW'(STARVE_LIM)) starve = 1'b1;
      end
   end

   assign issue_grant = advance & issue_req & ~starve & lat_ok & ~res_hit;
   assign issue_l1    = issue_grant & (issue_lat == LW'(1));
   assign slot_free   = ~res_q[1] & ~issue_l1;

   wb_rr_arbiter_m1 u_arb (
      .clk    (clk),
      .srst_i (sync_rst),
      .en_i   (advance & slot_free),
      .req_i  (var_req),
      .gnt_o  (var_grant)
   );

   // Slot k next cycle is slot k+1 now; a latency-L issue lands in entry L-1 after the shift.
   genvar gi;
   generate
      for (gi = 1; gi < MAX_LAT; gi++) begin : g_slot
         assign res_d[gi] = res_q[gi+1] | (issue_grant & (issue_lat == LW'(gi + 1)));
         assign own_d[gi] = (issue_grant && (issue_lat == LW'(gi + 1))) ? issue_src : own_q[gi+1];
      end
      for (gi = 0; gi < 2; gi++) begin : g_wait
         assign wait_d[gi] = (var_req[gi] && !var_grant[gi])
                           ? ((wait_q[gi] >= WW'(STARVE_LIM)) ? wait_q[gi] : wait_q[gi] + WW'(1))
                           : '0;
      end
   endgenerate
   assign res_d[MAX_LAT] = 1'b0;
   assign own_d[MAX_LAT] = WB_ALU;

   always_comb begin
      wb_valid_d = res_q[1] | issue_l1 | (|var_grant);
      wb_src_d   = WB_ALU;
      if (res_q[1])          wb_src_d = own_q[1];
      else if (issue_l1)     wb_src_d = issue_src;
      else if (var_grant[0]) wb_src_d = WB_DIV;
      else if (var_grant[1]) wb_src_d = WB_LSU;
   end

   always_ff @(posedge clk) begin
      if (sync_rst) begin
         res_q <= '0;
         for (int k = 1; k <= MAX_LAT; k++) own_q[k] <= WB_ALU;
         wait_q[0]  <= '0;
         wait_q[1]  <= '0;
         wb_valid_q <= 1'b0;
         wb_src_q   <= WB_ALU;
      end else if (clk_en) begin
         res_q      <= res_d;
         own_q      <= own_d;
         wait_q     <= wait_d;
         wb_valid_q <= wb_valid_d;
         wb_src_q   <= wb_src_d;
      end
   end

   assign wb_valid = wb_valid_q;
   assign wb_src   = wb_src_q;
   assign busy_map = res_q;

`ifdef WB_SCHED_STATS_EN
   logic [15:0] hold_cnt_q, vwait_cnt_q;

   always_ff @(posedge clk) begin
      if (sync_rst) begin
         hold_cnt_q  <= '0;
         vwait_cnt_q <= '0;
      end else if (clk_en) begin
         if (issue_req && !issue_grant && hold_cnt_q != 16'hFFFF)
            hold_cnt_q <= hold_cnt_q + 16'd1;
         if (((var_req & ~var_grant) != 2'b00) && vwait_cnt_q != 16'hFFFF)
            vwait_cnt_q <= vwait_cnt_q + 16'd1;
      end
   end

   assign stat_issue_hold = hold_cnt_q;
   assign stat_var_wait   = vwait_cnt_q;
`endif

   a_one_src: assert property (@(posedge clk) disable iff (sync_rst)
      $onehot0({res_q[1], issue_l1, var_grant}));
   a_fixed_src: assert property (@(posedge clk) disable iff (sync_rst)
      issue_grant |-> is_fixed_src(issue_src));

endmodule

// File: tb/tb_wb_slot_scheduler_m1.sv
// Bench for wb_slot_scheduler_m1: directed vector table, starvation sequence, randomized model check.
module tb_wb_slot_scheduler_m1;
   import m1_wb_pkg::*;

   localparam int MAX_LAT    = 8;
   localparam int STARVE_LIM = 4;
   localparam int LW         = 4;

   logic          clk = 1'b0;
   logic          sync_rst, clk_en, issue_req, issue_grant, wb_valid;
   wb_src_e       issue_src, wb_src;
   logic [LW-1:0] issue_lat;
   logic [1:0]    var_req, var_grant;
   logic [7:0]    busy_map;
`ifdef WB_SCHED_STATS_EN
   logic [15:0]   stat_issue_hold, stat_var_wait;
`endif

   always #5 clk = ~clk;

   wb_slot_scheduler_m1 dut (
      .clk         (clk),
      .sync_rst    (sync_rst),
      .clk_en      (clk_en),
      .issue_req   (issue_req),
      .issue_src   (issue_src),
      .issue_lat   (issue_lat),
      .issue_grant (issue_grant),
      .var_req     (var_req),
      .var_grant   (var_grant),
      .wb_valid    (wb_valid),
      .wb_src      (wb_src),
      .busy_map    (busy_map)
`ifdef WB_SCHED_STATS_EN
      ,
      .stat_issue_hold (stat_issue_hold),
      .stat_var_wait   (stat_var_wait)
`endif
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: bookings keyed by absolute (enabled-cycle) time.
   int      now;
   wb_src_e owner [int];
   int      wait_c [2];
   int      rr;
   bit      m_wbv;
   wb_src_e m_wbs;
   bit      m_ig;
   logic [1:0] m_vg;

   function automatic void model_eval();
      bit en, starve_m, taken;
      int L;
      en       = !sync_rst && clk_en;
      L        = int'(issue_lat);
      starve_m = (wait_c[0] >= STARVE_LIM) || (wait_c[1] >= STARVE_LIM);
      m_ig     = en && issue_req && !starve_m && L >= 1 && L <= MAX_LAT && !owner.exists(now + L);
      taken    = owner.exists(now + 1) || (m_ig && L == 1);
      m_vg     = 2'b00;
      if (en && !taken) begin
         if (var_req[rr])          m_vg[rr] = 1'b1;
         else if (var_req[1 - rr]) m_vg[1 - rr] = 1'b1;
      end
   endfunction

   function automatic logic [7:0] model_busy();
      logic [7:0] b;
      b = '0;
      for (int k = 1; k <= MAX_LAT; k++) b[k-1] = owner.exists(now + k);
      return b;
   endfunction

   function automatic void model_commit();
      if (sync_rst) begin
         owner.delete();
         now    = 0;
         wait_c = '{0, 0};
         rr     = 0;
         m_wbv  = 1'b0;
         m_wbs  = WB_ALU;
      end else if (clk_en) begin
         if (m_ig) owner[now + int'(issue_lat)] = issue_src;
         if (m_vg[0])      begin owner[now + 1] = WB_DIV; rr = 1; end
         else if (m_vg[1]) begin owner[now + 1] = WB_LSU; rr = 0; end
         for (int i = 0; i < 2; i++)
            wait_c[i] = (var_req[i] && !m_vg[i]) ? ((wait_c[i] < STARVE_LIM) ? wait_c[i] + 1 : wait_c[i]) : 0;
         owner.delete(now);
         now++;
         m_wbv = owner.exists(now);
         if (m_wbv) m_wbs = owner[now];
      end
   endfunction

   task automatic drive(input bit rst, input bit en, input bit ireq, input wb_src_e src,
                        input int lat, input logic [1:0] vreq);
      @(negedge clk);
      sync_rst  = rst;
      clk_en    = en;
      issue_req = ireq;
      issue_src = src;
      issue_lat = lat[LW-1:0];
      var_req   = vreq;
      #1;
      model_eval();
   endtask

   task automatic finish_cycle();
      @(posedge clk);
      model_commit();
   endtask

   typedef struct {
      bit rst; bit en; bit ireq; wb_src_e src; int lat; logic [1:0] vreq;
      bit chk_reg; bit e_ig; logic [1:0] e_vg; bit e_wbv; wb_src_e e_wbs; logic [7:0] e_busy;
   } vec_t;

   function automatic vec_t mk(bit rst, bit en, bit ireq, wb_src_e src, int lat, logic [1:0] vreq,
                               bit c, bit ig, logic [1:0] vg, bit wbv, wb_src_e wbs, logic [7:0] busy);
      vec_t v;
      v.rst = rst; v.en = en; v.ireq = ireq; v.src = src; v.lat = lat; v.vreq = vreq;
      v.chk_reg = c; v.e_ig = ig; v.e_vg = vg; v.e_wbv = wbv; v.e_wbs = wbs; v.e_busy = busy;
      return v;
   endfunction

   vec_t tbl [27];
   logic [1:0] vhold;

   initial begin
      sync_rst = 1'b1; clk_en = 1'b1; issue_req = 1'b0; issue_src = WB_ALU;
      issue_lat = '0; var_req = 2'b00;
      now = 0; rr = 0; wait_c = '{0, 0}; m_wbv = 1'b0; m_wbs = WB_ALU;

      // Registered columns show state before this row's clock edge.
      tbl[0]  = mk(1,1,1,WB_ALU,1,2'b11, 0, 0,2'b00,0,WB_ALU,8'h00);
      tbl[1]  = mk(1,1,1,WB_ALU,1,2'b11, 1, 0,2'b00,0,WB_ALU,8'h00);
      tbl[2]  = mk(0,1,1,WB_ALU,1,2'b00, 1, 1,2'b00,0,WB_ALU,8'h00);
      tbl[3]  = mk(0,1,0,WB_ALU,1,2'b00, 1, 0,2'b00,1,WB_ALU,8'h00);
      tbl[4]  = mk(0,1,1,WB_MUL,3,2'b00, 1, 1,2'b00,0,WB_ALU,8'h00);
      tbl[5]  = mk(0,1,1,WB_ALU,2,2'b00, 1, 0,2'b00,0,WB_ALU,8'h02);
      tbl[6]  = mk(0,1,1,WB_ALU,1,2'b00, 1, 0,2'b00,0,WB_ALU,8'h01);
      tbl[7]  = mk(0,1,1,WB_MUL,3,2'b00, 1, 1,2'b00,1,WB_MUL,8'h00);
      tbl[8]  = mk(0,1,1,WB_ALU,1,2'b00, 1, 1,2'b00,0,WB_ALU,8'h02);
      tbl[9]  = mk(0,1,0,WB_ALU,0,2'b00, 1, 0,2'b00,1,WB_ALU,8'h01);
      tbl[10] = mk(0,1,1,WB_ALU,0,2'b00, 1, 0,2'b00,1,WB_MUL,8'h00);
      tbl[11] = mk(0,1,1,WB_ALU,9,2'b00, 1, 0,2'b00,0,WB_ALU,8'h00);
      tbl[12] = mk(0,1,1,WB_MUL,8,2'b00, 1, 1,2'b00,0,WB_ALU,8'h00);
      tbl[13] = mk(0,1,0,WB_ALU,0,2'b11, 1, 0,2'b01,0,WB_ALU,8'h40);
      tbl[14] = mk(0,1,0,WB_ALU,0,2'b11, 1, 0,2'b10,1,WB_DIV,8'h20);
      tbl[15] = mk(0,1,0,WB_ALU,0,2'b00, 1, 0,2'b00,1,WB_LSU,8'h10);
      tbl[16] = mk(0,0,1,WB_ALU,1,2'b11, 1, 0,2'b00,0,WB_ALU,8'h08);
      tbl[17] = mk(0,0,1,WB_ALU,1,2'b11, 1, 0,2'b00,0,WB_ALU,8'h08);
      tbl[18] = mk(0,0,1,WB_ALU,1,2'b11, 1, 0,2'b00,0,WB_ALU,8'h08);
      tbl[19] = mk(0,1,0,WB_ALU,0,2'b00, 1, 0,2'b00,0,WB_ALU,8'h08);
      tbl[20] = mk(0,1,0,WB_ALU,0,2'b00, 1, 0,2'b00,0,WB_ALU,8'h04);
      tbl[21] = mk(0,1,0,WB_ALU,0,2'b00, 1, 0,2'b00,0,WB_ALU,8'h02);
      tbl[22] = mk(0,1,0,WB_ALU,0,2'b00, 1, 0,2'b00,0,WB_ALU,8'h01);
      tbl[23] = mk(0,0,1,WB_ALU,1,2'b01, 1, 0,2'b00,1,WB_MUL,8'h00);
      tbl[24] = mk(0,0,1,WB_ALU,1,2'b01, 1, 0,2'b00,1,WB_MUL,8'h00);
      tbl[25] = mk(0,1,0,WB_ALU,0,2'b00, 1, 0,2'b00,1,WB_MUL,8'h00);
      tbl[26] = mk(0,1,0,WB_ALU,0,2'b00, 1, 0,2'b00,0,WB_ALU,8'h00);

      for (int i = 0; i < 27; i++) begin
         drive(tbl[i].rst, tbl[i].en, tbl[i].ireq, tbl[i].src, tbl[i].lat, tbl[i].vreq);
         $display("vec %0d: rst=%0d en=%0d ireq=%0d lat=%0d vreq=%b -> ig=%0d vg=%b wbv=%0d wbs=%0d busy=%h",
                  i, tbl[i].rst, tbl[i].en, tbl[i].ireq, tbl[i].lat, tbl[i].vreq,
                  issue_grant, var_grant, wb_valid, wb_src, busy_map);
         chk($sformatf("vec%0d.issue_grant", i), 32'(issue_grant), 32'(tbl[i].e_ig));
         chk($sformatf("vec%0d.var_grant", i), 32'(var_grant), 32'(tbl[i].e_vg));
         if (tbl[i].chk_reg) begin
            chk($sformatf("vec%0d.wb_valid", i), 32'(wb_valid), 32'(tbl[i].e_wbv));
            chk($sformatf("vec%0d.busy_map", i), 32'(busy_map), 32'(tbl[i].e_busy));
            if (tbl[i].e_wbv) chk($sformatf("vec%0d.wb_src", i), 32'(wb_src), 32'(tbl[i].e_wbs));
         end
         finish_cycle();
      end

      // LSU waiting against back-to-back ALU L=1 issues: fixed issue is held off on the fifth cycle.
      for (int c = 0; c < 6; c++) begin
         drive(0, 1, 1, WB_ALU, 1, (c < 5) ? 2'b10 : 2'b00);
         $display("starve %0d: ig=%0d vg=%b wbv=%0d wbs=%0d", c, issue_grant, var_grant, wb_valid, wb_src);
         chk($sformatf("starve%0d.issue_grant", c), 32'(issue_grant), (c == 4) ? 32'd0 : 32'd1);
         chk($sformatf("starve%0d.var_grant", c), 32'(var_grant), (c == 4) ? 32'd2 : 32'd0);
         if (c >= 1) begin
            chk($sformatf("starve%0d.wb_valid", c), 32'(wb_valid), 32'd1);
            chk($sformatf("starve%0d.wb_src", c), 32'(wb_src), (c == 5) ? 32'(WB_LSU) : 32'(WB_ALU));
         end
         finish_cycle();
      end

      vhold = 2'b00;
      for (int n = 0; n < 1500; n++) begin
         bit rst_r, en_r, ireq_r;
         wb_src_e src_r;
         int lat_r;
         rst_r  = ($urandom_range(0, 199) == 0);
         en_r   = ($urandom_range(0, 9) != 0);
         ireq_r = ($urandom_range(0, 3) != 0);
         src_r  = ($urandom_range(0, 1) != 0) ? WB_MUL : WB_ALU;
         lat_r  = $urandom_range(0, 9);
         for (int i = 0; i < 2; i++)
            if (!vhold[i] && $urandom_range(0, 3) == 0) vhold[i] = 1'b1;
         drive(rst_r, en_r, ireq_r, src_r, lat_r, vhold);
         $display("rnd %0d: rst=%0d en=%0d ireq=%0d lat=%0d vreq=%b -> ig=%0d vg=%b wbv=%0d busy=%h",
                  n, rst_r, en_r, ireq_r, lat_r, vhold, issue_grant, var_grant, wb_valid, busy_map);
         chk("rnd.issue_grant", 32'(issue_grant), 32'(m_ig));
         chk("rnd.var_grant", 32'(var_grant), 32'(m_vg));
         chk("rnd.wb_valid", 32'(wb_valid), 32'(m_wbv));
         chk("rnd.busy_map", 32'(busy_map), 32'(model_busy()));
         if (m_wbv) chk("rnd.wb_src", 32'(wb_src), 32'(m_wbs));
         if (rst_r) vhold = 2'b00;
         else       vhold = vhold & ~m_vg;
         finish_cycle();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
